// File: rtl/apu_len_pkg.sv
// Shared APU length-counter definitions: the 32-entry length table and its lookup.
// Also used by the DMC and frame-counter blocks.
package apu_len_pkg;

  localparam int LEN_W = 8;

  localparam logic [LEN_W-1:0] LEN_TBL [0:31] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  function automatic logic [LEN_W-1:0] len_lookup(input logic [4:0] idx);
    return LEN_TBL[idx];
  endfunction

endpackage

// File: rtl/apu_len_rom.sv
// Combinational 5->8 length-table decoder; every index code maps to a defined value.
module apu_len_rom
  import apu_len_pkg::*;
(
  input  logic [4:0]       idx,
  output logic [LEN_W-1:0] len
);

  assign len = len_lookup(idx);

endmodule

// File: rtl/apu_length_counter.sv
// Per-channel APU length counter: table load on register write, half-frame decrement,
// forced clear while the channel is disabled, and the channel-active flag.
module apu_length_counter
  import apu_len_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int TBL_INIT = 0
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             LEN_WR,
  input  logic [4:0]       LEN_IDX,
  input  logic             HALT,
  input  logic             CH_EN,
  input  logic             HF_TICK,
  output logic [CNT_W-1:0] LEN_CNT,
  output logic             ACTIVE
);

  localparam logic [CNT_W-1:0] RST_VAL = (TBL_INIT != 0) ? CNT_W'(LEN_TBL[0]) : '0;

  logic [LEN_W-1:0] tbl_len;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             nz, dec;

  apu_len_rom u_rom (
    .idx (LEN_IDX),
    .len (tbl_len)
  );

  assign nz  = (cnt != '0);
  // A decrementing tick wins over a same-edge write (the write is lost, as on the 2A03);
  // zero never decrements, so there is no wrap.
  assign dec = HF_TICK & ~HALT & nz;

  always_comb begin
    cnt_nxt = cnt;
    if (!CH_EN)      cnt_nxt = '0;
    else if (dec)    cnt_nxt = cnt - 1'b1;
    else if (LEN_WR) cnt_nxt = CNT_W'(tbl_len);
  end

  always_ff @(posedge CLK) begin
    if (RES) cnt <= RST_VAL;
    else     cnt <= cnt_nxt;
  end

  assign LEN_CNT = cnt;
  assign ACTIVE  = nz;

endmodule

// File: tb/tb_apu_length_counter.sv
// Scoreboard bench for apu_length_counter: each driven cycle queues the expected
// post-edge counter value, a monitor pops and compares it just after the edge.
module tb_apu_length_counter;

  localparam int CNT_W    = 8;
  localparam int TBL_INIT = 0;
  localparam int RV       = (TBL_INIT != 0) ? 10 : 0;

  localparam int REF_TBL [0:31] = '{
    10, 254, 20, 2, 40, 4, 80, 6, 160, 8, 60, 10, 14, 12, 26, 14,
    12, 16, 24, 18, 48, 20, 96, 22, 192, 24, 72, 26, 16, 28, 32, 30
  };

  typedef struct {
    string tag;
    int    cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             res, len_wr, halt, ch_en, hf_tick;
  logic [4:0]       len_idx;
  logic [CNT_W-1:0] len_cnt;
  logic             active;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  apu_length_counter #(.CNT_W(CNT_W), .TBL_INIT(TBL_INIT)) dut (
    .CLK     (clk),
    .RES     (res),
    .LEN_WR  (len_wr),
    .LEN_IDX (len_idx),
    .HALT    (halt),
    .CH_EN   (ch_en),
    .HF_TICK (hf_tick),
    .LEN_CNT (len_cnt),
    .ACTIVE  (active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs before the next rising edge and queue its expected result.
  task automatic cyc(input string tag, input bit r, input bit en, input bit wr,
                     input int idx, input bit h, input bit t, input int exp);
    exp_t e;
    @(negedge clk);
    res     = r;
    ch_en   = en;
    len_wr  = wr;
    len_idx = 5'(idx);
    halt    = h;
    hf_tick = t;
    e.tag = tag;
    e.cnt = exp;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, "_cnt"}, int'(len_cnt), e.cnt);
      chk({e.tag, "_act"}, int'(active), int'(e.cnt != 0));
    end
  end

  initial begin
    res = 1'b1; ch_en = 1'b0; len_wr = 1'b0; len_idx = '0; halt = 1'b0; hf_tick = 1'b0;

    // reset, then first load
    cyc("rst0", 1, 0, 0, 0, 0, 0, RV);
    cyc("rst1", 1, 1, 1, 1, 0, 1, RV);
    cyc("ld254", 0, 1, 1, 1, 0, 0, 254);

    // short count down to sticky zero
    cyc("ld2",   0, 1, 1, 3, 0, 0, 2);
    cyc("tick1", 0, 1, 0, 0, 0, 1, 1);
    cyc("tick0", 0, 1, 0, 0, 0, 1, 0);
    cyc("stick", 0, 1, 0, 0, 0, 1, 0);
    cyc("hold0", 0, 1, 0, 0, 0, 0, 0);

    // halt suppresses decrement
    cyc("ld10", 0, 1, 1, 0, 0, 0, 10);
    for (int i = 0; i < 5; i++) cyc("halt", 0, 1, 0, 0, 1, 1, 10);
    cyc("unhalt", 0, 1, 0, 0, 0, 1, 9);

    // write coinciding with a tick
    cyc("wr_drop", 0, 1, 1, 8, 0, 1, 8);
    cyc("clr",     0, 0, 0, 0, 0, 0, 0);
    cyc("wr_at0",  0, 1, 1, 8, 0, 1, 160);
    cyc("wr_halt", 0, 1, 1, 2, 1, 1, 20);

    // channel disable
    cyc("ld40",    0, 1, 1, 4, 0, 0, 40);
    cyc("dis",     0, 0, 0, 0, 0, 0, 0);
    cyc("dis_wr",  0, 0, 1, 4, 0, 0, 0);
    cyc("dis_tk",  0, 0, 1, 1, 0, 1, 0);
    cyc("reen",    0, 1, 0, 0, 0, 0, 0);

    // reset mid-count
    cyc("ld192",   0, 1, 1, 24, 0, 0, 192);
    cyc("tk191",   0, 1, 0, 0, 1, 0, 192);
    cyc("tk191b",  0, 1, 0, 0, 0, 1, 191);
    cyc("midrst",  1, 1, 1, 5, 0, 1, RV);
    cyc("postrst", 0, 1, 0, 0, 1, 0, RV);

    // full table sweep, alternating with a decrement to catch stale loads
    for (int i = 0; i < 32; i++) begin
      cyc($sformatf("tbl%0d", i), 0, 1, 1, i, 0, 0, REF_TBL[i]);
      cyc($sformatf("tbl%0d_dec", i), 0, 1, 0, 0, 0, 1, REF_TBL[i] - 1);
    end

    cyc("idle", 0, 1, 0, 0, 0, 0, REF_TBL[31] - 1);
    @(negedge clk);
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
